// File: rtl/io_responder_pkg.sv
// io_pkg: values shared by the programmed-I/O responder and its queues.
//   DATA_W     : default data word width on both CPU channels
//   DEPTH      : default entries per queue (power of two, >= 2)
//   hs_state_t : four-phase handshake FSM states
package io_pkg;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 4;

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } hs_state_t;
endpackage

// File: rtl/io_responder_sync_fifo.sv
// sync_fifo: single-clock FIFO with an occupancy counter.
//   clk, rst_b : clock, async active-low reset (empties the queue)
//   i_push/i_din : write request and data (ignored while full)
//   i_pop        : read request (ignored while empty)
//   o_dout       : head of queue, combinational from storage
//   o_full/o_empty/o_count : status
module sync_fifo
    import io_pkg::*;
#(
    parameter int DATA_W = io_pkg::DATA_W,
    parameter int DEPTH  = io_pkg::DEPTH,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic [DATA_W-1:0] i_din,
    output logic [DATA_W-1:0] o_dout,
    output logic              o_full,
    output logic              o_empty,
    output logic [CNT_W-1:0]  o_count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_wr;
    logic              w_rd;

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_dout  = r_mem[r_rd_ptr];

    assign w_wr = i_push && !o_full;
    assign w_rd = i_pop  && !o_empty;

    // Storage needs no reset; the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= i_din;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/io_responder.sv
// io_responder: device side of the CPU's programmed-I/O channels.
//   clk, rst_b                          : clock, async active-low reset
//   inp_req/inp_ack/inp_data            : CPU input channel (4-phase)
//   out_req/out_data/out_ack            : CPU output channel (4-phase)
//   host_in_valid/host_in_data/host_in_ready    : host fills input queue
//   host_out_valid/host_out_data/host_out_ready : host drains output queue
//   in_count/out_count                  : queue occupancies
module io_responder
    import io_pkg::*;
#(
    parameter int DATA_W = io_pkg::DATA_W,
    parameter int DEPTH  = io_pkg::DEPTH,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              inp_req,
    output logic              inp_ack,
    output logic [DATA_W-1:0] inp_data,
    input  logic              out_req,
    input  logic [DATA_W-1:0] out_data,
    output logic              out_ack,
    input  logic              host_in_valid,
    input  logic [DATA_W-1:0] host_in_data,
    output logic              host_in_ready,
    output logic              host_out_valid,
    output logic [DATA_W-1:0] host_out_data,
    input  logic              host_out_ready,
    output logic [CNT_W-1:0]  in_count,
    output logic [CNT_W-1:0]  out_count
);
    hs_state_t         r_in_state;
    hs_state_t         r_out_state;
    logic [DATA_W-1:0] w_in_head;
    logic              w_in_full;
    logic              w_in_empty;
    logic              w_out_full;
    logic              w_out_empty;
    logic              w_in_pop;
    logic              w_out_push;

    // Only the IDLE->ACK edge moves a word, so a long-held req costs one entry.
    assign w_in_pop   = (r_in_state  == IDLE) && inp_req && !w_in_empty;
    assign w_out_push = (r_out_state == IDLE) && out_req && !w_out_full;

    assign host_in_ready  = !w_in_full;
    assign host_out_valid = !w_out_empty;

    sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_in_q (
        .clk     (clk),
        .rst_b   (rst_b),
        .i_push  (host_in_valid),
        .i_pop   (w_in_pop),
        .i_din   (host_in_data),
        .o_dout  (w_in_head),
        .o_full  (w_in_full),
        .o_empty (w_in_empty),
        .o_count (in_count)
    );

    sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_out_q (
        .clk     (clk),
        .rst_b   (rst_b),
        .i_push  (w_out_push),
        .i_pop   (host_out_ready),
        .i_din   (out_data),
        .o_dout  (host_out_data),
        .o_full  (w_out_full),
        .o_empty (w_out_empty),
        .o_count (out_count)
    );

    // Input channel: waits in IDLE (no timeout) until a word is available.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_in_state <= IDLE;
            inp_ack    <= 1'b0;
            inp_data   <= '0;
        end else begin
            case (r_in_state)
                IDLE: if (w_in_pop) begin
                    inp_data   <= w_in_head;
                    inp_ack    <= 1'b1;
                    r_in_state <= ACK;
                end
                ACK: if (!inp_req) begin
                    inp_ack    <= 1'b0;
                    r_in_state <= IDLE;
                end
                default: r_in_state <= IDLE;
            endcase
        end
    end

    // Output channel: stalls in IDLE while the output queue is full.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_out_state <= IDLE;
            out_ack     <= 1'b0;
        end else begin
            case (r_out_state)
                IDLE: if (w_out_push) begin
                    out_ack     <= 1'b1;
                    r_out_state <= ACK;
                end
                ACK: if (!out_req) begin
                    out_ack     <= 1'b0;
                    r_out_state <= IDLE;
                end
                default: r_out_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_io_responder.sv
module tb_io_responder;
    import io_pkg::*;

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst_b;
    logic              inp_req, inp_ack;
    logic [DATA_W-1:0] inp_data;
    logic              out_req, out_ack;
    logic [DATA_W-1:0] out_data;
    logic              host_in_valid, host_in_ready;
    logic [DATA_W-1:0] host_in_data;
    logic              host_out_valid, host_out_ready;
    logic [DATA_W-1:0] host_out_data;
    logic [CNT_W-1:0]  in_count, out_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    io_responder #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_b(rst_b),
        .inp_req(inp_req), .inp_ack(inp_ack), .inp_data(inp_data),
        .out_req(out_req), .out_data(out_data), .out_ack(out_ack),
        .host_in_valid(host_in_valid), .host_in_data(host_in_data),
        .host_in_ready(host_in_ready),
        .host_out_valid(host_out_valid), .host_out_data(host_out_data),
        .host_out_ready(host_out_ready),
        .in_count(in_count), .out_count(out_count)
    );

    // Inputs change and outputs are sampled 1ns after each rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_b = 1'b0; inp_req = 0; out_req = 0; out_data = '0;
        host_in_valid = 0; host_in_data = '0; host_out_ready = 0;
        cyc(); cyc();
        checks++;
        if (inp_ack !== 1'b0 || out_ack !== 1'b0 || inp_data !== '0) begin
            errors++;
            $display("FAIL reset_acks: inp_ack=%b out_ack=%b inp_data=%h want 0 0 0", inp_ack, out_ack, inp_data);
        end
        checks++;
        if (in_count !== '0 || out_count !== '0 || host_out_valid !== 1'b0 || host_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_queues: in_count=%0d out_count=%0d hov=%b hir=%b want 0 0 0 1",
                     in_count, out_count, host_out_valid, host_in_ready);
        end
        rst_b = 1'b1;
        cyc();
    endtask

    task automatic host_push(input logic [DATA_W-1:0] w);
        host_in_valid = 1'b1; host_in_data = w;
        cyc();
        host_in_valid = 1'b0;
    endtask

    // One full CPU input handshake against an expected word and remaining count.
    task automatic cpu_read(input string nm, input logic [DATA_W-1:0] exp_w, input int exp_cnt);
        inp_req = 1'b1;
        #1;
        checks++;
        if (inp_ack !== 1'b0) begin
            errors++; $display("FAIL %s_pre_ack: got %b want 0", nm, inp_ack);
        end
        cyc();
        checks++;
        if (inp_ack !== 1'b1 || inp_data !== exp_w || in_count !== CNT_W'(exp_cnt)) begin
            errors++;
            $display("FAIL %s: ack=%b data=%h cnt=%0d want 1 %h %0d", nm, inp_ack, inp_data, in_count, exp_w, exp_cnt);
        end
        inp_req = 1'b0;
        cyc();
        checks++;
        if (inp_ack !== 1'b0) begin
            errors++; $display("FAIL %s_release: ack=%b want 0", nm, inp_ack);
        end
    endtask

    task automatic test_prefill();
        host_push(16'h1234);
        host_push(16'hBEEF);
        checks++;
        if (in_count !== CNT_W'(2)) begin
            errors++; $display("FAIL prefill_count: got %0d want 2", in_count);
        end
        cpu_read("prefill_0", 16'h1234, 1);
        cpu_read("prefill_1", 16'hBEEF, 0);
    endtask

    task automatic test_empty_wait();
        int bad = 0;
        inp_req = 1'b1;
        repeat (10) begin
            cyc();
            if (inp_ack !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL empty_wait: ack high in %0d of 10 cycles, want 0", bad);
        end
        host_push(16'h00A5);
        checks++;
        if (inp_ack !== 1'b0) begin
            errors++; $display("FAIL empty_push_edge: ack=%b want 0", inp_ack);
        end
        cyc();
        checks++;
        if (inp_ack !== 1'b1 || inp_data !== 16'h00A5 || in_count !== '0) begin
            errors++;
            $display("FAIL empty_late_ack: ack=%b data=%h cnt=%0d want 1 00a5 0", inp_ack, inp_data, in_count);
        end
        inp_req = 1'b0;
        cyc();
    endtask

    task automatic test_held();
        logic [DATA_W-1:0] w0, w1;
        int bad = 0;
        w0 = DATA_W'($urandom); w1 = DATA_W'($urandom);
        host_push(w0);
        host_push(w1);
        inp_req = 1'b1;
        cyc();
        repeat (5) begin
            cyc();
            if (inp_ack !== 1'b1 || inp_data !== w0 || in_count !== CNT_W'(1)) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL held_req: %0d bad cycles (ack/data/cnt), want 0", bad);
        end
        inp_req = 1'b0;
        cyc();
        checks++;
        if (inp_ack !== 1'b0 || inp_data !== w0 || in_count !== CNT_W'(1)) begin
            errors++;
            $display("FAIL held_release: ack=%b data=%h cnt=%0d want 0 %h 1", inp_ack, inp_data, in_count, w0);
        end
        cpu_read("held_next", w1, 0);
    endtask

    task automatic test_out_full();
        for (int k = 1; k <= 5; k++) begin
            out_data = DATA_W'(k); out_req = 1'b1;
            cyc();
            checks++;
            if (out_ack !== (k <= DEPTH)) begin
                errors++; $display("FAIL out_word_%0d_ack: got %b want %b", k, out_ack, (k <= DEPTH));
            end
            if (k <= DEPTH) begin
                out_req = 1'b0;
                cyc();
            end
        end
        checks++;
        if (out_count !== CNT_W'(DEPTH) || host_out_data !== 16'h0001 || host_out_valid !== 1'b1) begin
            errors++;
            $display("FAIL out_full_state: cnt=%0d head=%h valid=%b want %0d 0001 1", out_count, host_out_data, host_out_valid, DEPTH);
        end
        host_out_ready = 1'b1;
        cyc();
        host_out_ready = 1'b0;
        checks++;
        if (out_ack !== 1'b0 || out_count !== CNT_W'(DEPTH-1)) begin
            errors++; $display("FAIL out_pop_edge: ack=%b cnt=%0d want 0 %0d", out_ack, out_count, DEPTH-1);
        end
        cyc();
        checks++;
        if (out_ack !== 1'b1 || out_count !== CNT_W'(DEPTH)) begin
            errors++; $display("FAIL out_stalled_ack: ack=%b cnt=%0d want 1 %0d", out_ack, out_count, DEPTH);
        end
        out_req = 1'b0;
        cyc();
        host_out_ready = 1'b1;
        for (int k = 2; k <= 5; k++) begin
            #1;
            checks++;
            if (host_out_valid !== 1'b1 || host_out_data !== DATA_W'(k)) begin
                errors++; $display("FAIL out_drain_%0d: valid=%b data=%h want 1 %h", k, host_out_valid, host_out_data, DATA_W'(k));
            end
            cyc();
        end
        host_out_ready = 1'b0;
        checks++;
        if (host_out_valid !== 1'b0 || out_count !== '0) begin
            errors++; $display("FAIL out_drained: valid=%b cnt=%0d want 0 0", host_out_valid, out_count);
        end
    endtask

    // Random host pushes and CPU handshakes on both channels; scoreboards
    // are plain queues of words in acceptance order.
    task automatic test_stream();
        logic [DATA_W-1:0] in_sb[$], out_sb[$];
        logic [DATA_W-1:0] words[10];
        int sent = 0, got = 0, osent = 0, ogot = 0, model_cnt = 0;
        int bad_order = 0, bad_cnt = 0, cyc_n = 0;
        logic prev_ack = 1'b0, prev_oack = 1'b0, push_ok;
        foreach (words[i]) words[i] = DATA_W'($urandom);
        while ((got < 10 || ogot < 10) && cyc_n < 600) begin
            host_in_valid = (sent < 10) && ($urandom_range(0, 2) != 0);
            host_in_data  = (sent < 10) ? words[sent] : '0;
            if (!inp_req && !inp_ack && $urandom_range(0, 1) == 1) inp_req = 1'b1;
            else if (inp_req && inp_ack && $urandom_range(0, 3) != 0) inp_req = 1'b0;
            if (!out_req && !out_ack && osent < 10 && $urandom_range(0, 1) == 1) begin
                out_req = 1'b1; out_data = DATA_W'($urandom);
                out_sb.push_back(out_data); osent++;
            end else if (out_req && out_ack) out_req = 1'b0;
            host_out_ready = $urandom_range(0, 1);
            #1;
            push_ok = host_in_valid && (model_cnt < DEPTH);
            if (host_out_ready && host_out_valid) begin
                if (out_sb.size() == 0 || host_out_data !== out_sb[0]) bad_order++;
                else void'(out_sb.pop_front());
                ogot++;
            end
            cyc(); cyc_n++;
            if (push_ok) begin
                in_sb.push_back(words[sent]); sent++; model_cnt++;
            end
            if (inp_ack && !prev_ack) begin
                if (in_sb.size() == 0 || inp_data !== in_sb[0]) bad_order++;
                else void'(in_sb.pop_front());
                got++; model_cnt--;
            end
            prev_ack = inp_ack; prev_oack = out_ack;
            if (in_count !== CNT_W'(model_cnt) || in_count > CNT_W'(DEPTH)) bad_cnt++;
        end
        host_in_valid = 0; inp_req = 0; out_req = 0; host_out_ready = 0;
        cyc(); cyc();
        checks++;
        if (got != 10 || ogot != 10) begin
            errors++; $display("FAIL stream_complete: in=%0d out=%0d words in %0d cycles, want 10 10", got, ogot, cyc_n);
        end
        checks++;
        if (bad_order != 0) begin
            errors++; $display("FAIL stream_order: %0d out-of-order words, want 0", bad_order);
        end
        checks++;
        if (bad_cnt != 0) begin
            errors++; $display("FAIL stream_in_count: %0d cycles disagree with model, want 0", bad_cnt);
        end
    endtask

    task automatic test_reset_mid();
        host_push(16'h1111);
        host_push(16'h2222);
        host_push(16'h3333);
        inp_req = 1'b1;
        cyc();
        #2 rst_b = 1'b0;
        #1;
        checks++;
        if (inp_ack !== 1'b0 || in_count !== '0 || host_in_ready !== 1'b1 || inp_data !== '0) begin
            errors++;
            $display("FAIL reset_mid: ack=%b cnt=%0d ready=%b data=%h want 0 0 1 0", inp_ack, in_count, host_in_ready, inp_data);
        end
        inp_req = 1'b0;
        cyc();
        rst_b = 1'b1;
        cyc();
        host_push(16'h4444);
        cpu_read("after_reset", 16'h4444, 0);
    endtask

    initial begin
        test_reset();
        test_prefill();
        test_empty_wait();
        test_held();
        test_out_full();
        test_stream();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/io_responder.md
Name: io_responder

Overview:
- Device-side responder for the CPU's programmed-I/O channels.
- Answers the CPU's input request (inp_req/inp_ack/inp_data) from an input queue that a host/testbench side fills.
- Accepts the CPU's output request (out_req/out_ack/out_data) into an output queue that the host side drains.
- Sits beside the CPU at top level, between the CPU's I/O pins and the external stimulus/monitor logic.

Parameters:
- DATA_W, 16, width of every data word on both channels.
- DEPTH, 4, entries per queue; power of two, minimum 2.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst_b  in  1  asynchronous active-low reset.
- inp_req  in  1  CPU requests an input word.
- inp_ack  out  1  input word valid on inp_data.
- inp_data  out  DATA_W  word returned to the CPU.
- out_req  in  1  CPU presents an output word.
- out_data  in  DATA_W  word from the CPU; stable while out_req=1.
- out_ack  out  1  output word captured.
- host_in_valid  in  1  host pushes a word into the input queue.
- host_in_data  in  DATA_W  pushed word.
- host_in_ready  out  1  input queue not full.
- host_out_valid  out  1  output queue not empty.
- host_out_data  out  DATA_W  head of the output queue.
- host_out_ready  in  1  host pops the output queue.
- in_count  out  CNT_W  input queue occupancy.
- out_count  out  CNT_W  output queue occupancy.

Behaviour:
- Reset (async, rst_b=0), all registered outputs go to 0:
  - both FSMs go to IDLE; inp_ack=0, out_ack=0, inp_data=0.
  - both queues are emptied: in_count=0, out_count=0, host_out_valid=0.
  - host_in_ready=1.
- Reset mid-handshake: ack drops immediately, and any captured or in-flight word is discarded.
- Both CPU channels use a four-phase handshake: req rises, ack rises, req falls, ack falls. The CPU raises req only while ack=0.
- Input FSM (states IDLE, ACK):
  - IDLE -> ACK at the edge where inp_req=1 and the input queue is non-empty. On that edge the queue head is popped into inp_data and inp_ack is set to 1.
  - The ack is registered, so it appears 1 cycle after the edge that samples req.
  - ACK holds inp_ack=1 and inp_data constant while inp_req=1.
  - ACK -> IDLE at the first edge with inp_req=0; inp_ack is cleared there. inp_data keeps its last value.
  - inp_req=1 with an empty queue: stay in IDLE with ack=0 and wait indefinitely. No error and no timeout.
- Output FSM (states IDLE, ACK):
  - IDLE -> ACK at the edge where out_req=1 and the output queue is not full. On that edge out_data is pushed and out_ack is set to 1.
  - ACK -> IDLE at the first edge with out_req=0; out_ack is cleared there.
  - Output queue full: stall in IDLE; the word is captured once the host pops.
- Exactly one push or pop per handshake, regardless of how long req is held.
- Queues are synchronous FIFOs with a storage array, rd/wr pointers wrapping modulo DEPTH, and a CNT_W counter.
  - full = (count==DEPTH); empty = (count==0).
  - host_in_ready = !full(in); host_out_valid = !empty(out).
  - host_out_data shows the head combinationally from storage.
  - A push while full or a pop while empty is ignored; pointers and count do not change.
  - Push and pop in the same cycle (queue neither empty nor full): both take effect and count is unchanged.
  - Host push and CPU pop of the input queue in the same cycle are allowed; the same applies to the output queue.
- Word order is strict FIFO on both paths; pointer wrap-around must not reorder words.
- The two channels are fully independent and may handshake in the same cycle.

Decomposition:
- Shared package io_pkg:
  - DATA_W default.
  - DEPTH default.
  - Handshake FSM state encoding: IDLE=1'b0, ACK=1'b1.
- Sub-module sync_fifo (DATA_W, DEPTH): push, pop, din, dout, full, empty, count.
  - Instantiated twice, once for the input queue and once for the output queue.
- The two FSMs live in io_responder itself.

Test Plan:
- Input, pre-filled: host pushes 0x1234 then 0xBEEF; CPU does two inp_req handshakes -> inp_ack rises 1 cycle after each req sample; inp_data=0x1234, then 0xBEEF; in_count 2->1->0.
- Input, empty: inp_req=1 held 10 cycles with an empty queue, then host pushes 0x00A5 -> inp_ack stays 0 for all 10 cycles, then rises 1 cycle after the push edge with inp_data=0x00A5.
- Output, full stall: DEPTH=4; CPU sends 0x0001..0x0005 with host_out_ready=0 -> first 4 acked, out_count=4; 5th out_req gets no ack. One host pop of 0x0001 -> 5th acked next cycle; host then drains 0x0002..0x0005 in order.
- Wrap and simultaneity: 10 input words streamed with a host push and a CPU pop landing in the same cycle -> all 10 words arrive in order; in_count never exceeds DEPTH; no word is lost at pointer wrap.
- Held request: inp_req held 5 cycles after ack -> exactly one pop; inp_data stable; ack falls the cycle after req drops.
- Reset mid-handshake: rst_b=0 while in ACK with 2 words queued -> inp_ack=0, in_count=0 and host_in_ready=1 immediately, without waiting for a clock edge.
